ex_operand_stage: RTL

//  ID/EX pipeline register plus operand selection/forwarding feeding the EX-stage ALU.

---
 rtl/ex_operand_stage_if.sv | 53 +++++
 rtl/ex_operand_stage.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ex_operand_stage_if.sv
// ID/EX operand-stage bundle: decode/hazard inputs, forwarding sources and ALU-facing outputs.
// The stage drives the o_* fields; the surrounding pipeline drives everything else.
interface ex_operand_stage_if #(
  parameter int NB_BITS = 32,
  parameter int NB_OPE  = 4,
  parameter int NB_REG  = 5
);
  logic               i_valid;
  logic               i_stall;
  logic               i_flush;
  logic [NB_BITS-1:0] i_rs_data;
  logic [NB_BITS-1:0] i_rt_data;
  logic [NB_BITS-1:0] i_imm;
  logic [4:0]         i_shamt;
  logic [NB_BITS-1:0] i_pc_plus4;
  logic [NB_REG-1:0]  i_rs_addr;
  logic [NB_REG-1:0]  i_rt_addr;
  logic [NB_REG-1:0]  i_rd_addr;
  logic [NB_OPE-1:0]  i_ope_sel;
  logic               i_src_a_shamt;
  logic               i_src_a_pc;
  logic               i_src_b_imm;
  logic               i_reg_write;
  logic               i_mem_reg_write;
  logic [NB_REG-1:0]  i_mem_rd_addr;
  logic [NB_BITS-1:0] i_mem_data;
  logic               i_wb_reg_write;
  logic [NB_REG-1:0]  i_wb_rd_addr;
  logic [NB_BITS-1:0] i_wb_data;
  logic [NB_BITS-1:0] o_data_a;
  logic [NB_BITS-1:0] o_data_b;
  logic [NB_OPE-1:0]  o_ope_sel;
  logic [NB_BITS-1:0] o_store_data;
  logic [NB_REG-1:0]  o_rd_addr;
  logic               o_reg_write;
  logic               o_valid;

  modport master (
    output i_valid, i_stall, i_flush, i_rs_data, i_rt_data, i_imm, i_shamt, i_pc_plus4,
           i_rs_addr, i_rt_addr, i_rd_addr, i_ope_sel, i_src_a_shamt, i_src_a_pc,
           i_src_b_imm, i_reg_write, i_mem_reg_write, i_mem_rd_addr, i_mem_data,
           i_wb_reg_write, i_wb_rd_addr, i_wb_data,
    input  o_data_a, o_data_b, o_ope_sel, o_store_data, o_rd_addr, o_reg_write, o_valid
  );

  modport slave (
    input  i_valid, i_stall, i_flush, i_rs_data, i_rt_data, i_imm, i_shamt, i_pc_plus4,
           i_rs_addr, i_rt_addr, i_rd_addr, i_ope_sel, i_src_a_shamt, i_src_a_pc,
           i_src_b_imm, i_reg_write, i_mem_reg_write, i_mem_rd_addr, i_mem_data,
           i_wb_reg_write, i_wb_rd_addr, i_wb_data,
    output o_data_a, o_data_b, o_ope_sel, o_store_data, o_rd_addr, o_reg_write, o_valid
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB forwarding and ALU operand selection.
// Stall holds control but keeps refreshing rs/rt so a WB producer retiring mid-stall is kept.
module ex_operand_stage #(
  parameter int NB_BITS = 32,
  parameter int NB_OPE  = 4,
  parameter int NB_REG  = 5
) (
  input logic               i_clk,
  input logic               i_rst_n,
  ex_operand_stage_if.slave bus
);
  localparam int NB_SHAMT = 5;

  // MEM beats WB; register 0 is hard-wired and never forwarded.
  function automatic logic [NB_BITS-1:0] fwd_value(
    input logic [NB_REG-1:0]  addr,
    input logic [NB_BITS-1:0] reg_value,
    input logic               mem_we,
    input logic [NB_REG-1:0]  mem_addr,
    input logic [NB_BITS-1:0] mem_data,
    input logic               wb_we,
    input logic [NB_REG-1:0]  wb_addr,
    input logic [NB_BITS-1:0] wb_data
  );
    logic [NB_BITS-1:0] result;
    if (addr == {NB_REG{1'b0}}) begin
      result = reg_value;
    end else if (mem_we && (mem_addr == addr)) begin
      result = mem_data;
    end else if (wb_we && (wb_addr == addr)) begin
      result = wb_data;
    end else begin
      result = reg_value;
    end
    return result;
  endfunction

  logic               valid_r;
  logic               reg_write_r;
  logic [NB_OPE-1:0]  ope_sel_r;
  logic [NB_REG-1:0]  rd_addr_r;
  logic [NB_REG-1:0]  rs_addr_r;
  logic [NB_REG-1:0]  rt_addr_r;
  logic [NB_BITS-1:0] rs_data_r;
  logic [NB_BITS-1:0] rt_data_r;
  logic [NB_BITS-1:0] imm_r;
  logic [NB_SHAMT-1:0] shamt_r;
  logic [NB_BITS-1:0] pc_plus4_r;
  logic               src_a_shamt_r;
  logic               src_a_pc_r;
  logic               src_b_imm_r;
  logic [NB_BITS-1:0] fwd_rs_s;
  logic [NB_BITS-1:0] fwd_rt_s;
  logic [NB_BITS-1:0] data_a_s;
  logic [NB_BITS-1:0] data_b_s;

  assign fwd_rs_s = fwd_value(rs_addr_r, rs_data_r, bus.i_mem_reg_write, bus.i_mem_rd_addr,
                              bus.i_mem_data, bus.i_wb_reg_write, bus.i_wb_rd_addr, bus.i_wb_data);
  assign fwd_rt_s = fwd_value(rt_addr_r, rt_data_r, bus.i_mem_reg_write, bus.i_mem_rd_addr,
                              bus.i_mem_data, bus.i_wb_reg_write, bus.i_wb_rd_addr, bus.i_wb_data);

  // Pipeline register: flush > stall > normal capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_r       <= 1'b0;
      reg_write_r   <= 1'b0;
      ope_sel_r     <= {NB_OPE{1'b0}};
      rd_addr_r     <= {NB_REG{1'b0}};
      rs_addr_r     <= {NB_REG{1'b0}};
      rt_addr_r     <= {NB_REG{1'b0}};
      rs_data_r     <= {NB_BITS{1'b0}};
      rt_data_r     <= {NB_BITS{1'b0}};
      imm_r         <= {NB_BITS{1'b0}};
      shamt_r       <= {NB_SHAMT{1'b0}};
      pc_plus4_r    <= {NB_BITS{1'b0}};
      src_a_shamt_r <= 1'b0;
      src_a_pc_r    <= 1'b0;
      src_b_imm_r   <= 1'b0;
    end else if (bus.i_flush) begin
      valid_r     <= 1'b0;
      reg_write_r <= 1'b0;
      ope_sel_r   <= {NB_OPE{1'b0}};
      rd_addr_r   <= {NB_REG{1'b0}};
    end else if (bus.i_stall) begin
      rs_data_r <= fwd_rs_s;
      rt_data_r <= fwd_rt_s;
    end else begin
      valid_r       <= bus.i_valid;
      reg_write_r   <= bus.i_reg_write & bus.i_valid;
      ope_sel_r     <= bus.i_ope_sel;
      rd_addr_r     <= bus.i_rd_addr;
      rs_addr_r     <= bus.i_rs_addr;
      rt_addr_r     <= bus.i_rt_addr;
      rs_data_r     <= bus.i_rs_data;
      rt_data_r     <= bus.i_rt_data;
      imm_r         <= bus.i_imm;
      shamt_r       <= bus.i_shamt;
      pc_plus4_r    <= bus.i_pc_plus4;
      src_a_shamt_r <= bus.i_src_a_shamt;
      src_a_pc_r    <= bus.i_src_a_pc;
      src_b_imm_r   <= bus.i_src_b_imm;
    end
  end

  // Operand A: link address wins over shift amount; ALU adds 4 to reach PC+8.
  always_comb begin
    data_a_s = fwd_rs_s;
    if (src_a_pc_r) begin
      data_a_s = pc_plus4_r;
    end else if (src_a_shamt_r) begin
      data_a_s = {{(NB_BITS-NB_SHAMT){1'b0}}, shamt_r};
    end else begin
      data_a_s = fwd_rs_s;
    end
  end

  // Operand B: immediate or forwarded rt.
  always_comb begin
    data_b_s = fwd_rt_s;
    if (src_b_imm_r) begin
      data_b_s = imm_r;
    end else begin
      data_b_s = fwd_rt_s;
    end
  end

  assign bus.o_data_a     = data_a_s;
  assign bus.o_data_b     = data_b_s;
  assign bus.o_store_data = fwd_rt_s;
  assign bus.o_ope_sel    = ope_sel_r;
  assign bus.o_rd_addr    = rd_addr_r;
  assign bus.o_reg_write  = reg_write_r;
  assign bus.o_valid      = valid_r;
endmodule
